// File: rtl/blk_f27271.sv
// ---------------------------------------------------------------------------
// blk_f27271 : parameterised register with write enable and sync reset
//
// A WIDTH-bit storage register. On each rising clock edge:
//   - rst=1 loads RESET_VAL. Reset has priority, so a write in the same
//     cycle is discarded.
//   - rst=0 and wen=1 loads din.
//   - rst=0 and wen=0 holds the current value.
// The output comes straight from the storage flops. No input has a
// combinational path to dout.
//
// Parameters
//   WIDTH      data width, 1..1024
//   RESET_VAL  reset value. Truncated or zero-extended to WIDTH bits.
//
// Ports (order is fixed so that positional instantiation binds correctly)
//   clk   in   1      clock, rising edge active
//   rst   in   1      synchronous reset, active-high
//   din   in   WIDTH  next-state data
//   dout  out  WIDTH  registered state
//   wen   in   1      write enable, active-high
//
// Configuration macro
//   REG_INIT_EN  when defined, the storage flops power up holding RESET_VAL.
//                This acts as a simulation initial value or an FPGA init
//                value. When not defined, the flops start unspecified and
//                no initialisation construct is emitted.
// ---------------------------------------------------------------------------
module blk_f27271 #(
  parameter int unsigned   WIDTH     = 1,
  parameter logic [1023:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // RESET_VAL is carried at the maximum legal width. Taking the low WIDTH
  // bits gives the required truncation. A narrower value supplied by the
  // user has already been zero-extended into the 1024-bit parameter.
  localparam logic [WIDTH-1:0] ResetValW = RESET_VAL[WIDTH-1:0];

`ifdef REG_INIT_EN
  // The declaration initialiser gives a power-up value without using an
  // initial process.
  logic [WIDTH-1:0] dout_q = ResetValW;
`else
  logic [WIDTH-1:0] dout_q;
`endif
  logic [WIDTH-1:0] dout_d;

  // Next-state data when not in reset: take din on a write, otherwise
  // recirculate. All bits are selected together, so there is no partial
  // write.
  always_comb begin
    dout_d = dout_q;
    if (wen) begin
      dout_d = din;
    end
  end

  // The storage flops. Reset is sampled only at the rising edge and wins
  // over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= ResetValW;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_blk_f27271.sv
// ---------------------------------------------------------------------------
// tb_blk_f27271 : self-checking bench for blk_f27271
//
// Two instances are tested:
//   dut32 : WIDTH=32, RESET_VAL=0x80000000. All three inputs are driven.
//   dut1  : WIDTH=1,  RESET_VAL=1, din tied to 0, wen tied to 1. This is a
//           one-shot flag that is set by reset and clears on the next edge.
//
// The driver applies inputs on the falling edge. It updates a behavioural
// model and pushes the expected post-edge outputs into a queue. A separate
// monitor pops one entry shortly after each rising edge and compares it
// with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_blk_f27271;

  typedef struct {
    logic [31:0] e32;
    logic        e1;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] din;
  logic [31:0] dout32;
  logic        rst1;
  logic        dout1;
  logic        zeroBit;
  logic        oneBit;

  expT         expQ[$];
  logic [31:0] model32;
  logic        model1;
  int          total = 0;
  int          bad   = 0;

  blk_f27271 #(.WIDTH(32), .RESET_VAL(32'h8000_0000)) dut32 (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout32),
    .wen (wen)
  );

  blk_f27271 #(.WIDTH(1), .RESET_VAL(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .din (zeroBit),
    .dout(dout1),
    .wen (oneBit)
  );

  always #5 clk = ~clk;

  // Compares one value and keeps the pass/fail counters.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs on the falling edge. The model is updated
  // from the register rules: reset wins, then a write loads din, otherwise
  // the value is held. The expected post-edge state is then queued.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] d,
                               input logic r1);
    expT item;
    @(negedge clk);
    rst  = r;
    wen  = w;
    din  = d;
    rst1 = r1;
    if (r)      model32 = 32'h8000_0000;
    else if (w) model32 = d;
    model1    = r1 ? 1'b1 : 1'b0;
    item.e32  = model32;
    item.e1   = model1;
    expQ.push_back(item);
  endtask

  // Wiggles the inputs between edges, including a short reset pulse that
  // does not span an edge. The outputs must not move during this. The
  // final input values then form an ordinary write cycle.
  task automatic applyGlitch(input logic [31:0] finalDin);
    expT item;
    @(negedge clk);
    rst  = 1'b0;
    wen  = 1'b0;
    rst1 = 1'b0;
    din  = $urandom;
    #1 rst = 1'b1; rst1 = 1'b1; wen = 1'b1;
    #1 rst = 1'b0; rst1 = 1'b0; din = $urandom;
    #1 wen = 1'b0;
    checkOutput("midcycle_dout32", dout32, model32);
    checkOutput("midcycle_dout1", {31'b0, dout1}, {31'b0, model1});
    wen = 1'b1;
    din = finalDin;
    model32   = finalDin;
    model1    = 1'b0;
    item.e32  = model32;
    item.e1   = model1;
    expQ.push_back(item);
  endtask

  // Monitor: one expected entry corresponds to each rising edge that the
  // driver has prepared.
  always @(posedge clk) begin
    expT item;
    #1;
    if (expQ.size() > 0) begin
      item = expQ.pop_front();
      checkOutput("dout32", dout32, item.e32);
      checkOutput("dout1", {31'b0, dout1}, {31'b0, item.e1});
    end
  end

  initial begin
    zeroBit = 1'b0;
    oneBit  = 1'b1;
    rst     = 1'b0;
    rst1    = 1'b0;
    wen     = 1'b0;
    din     = '0;
    model32 = '0;
    model1  = 1'b0;

`ifdef REG_INIT_EN
    #1;
    checkOutput("init_dout32", dout32, 32'h8000_0000);
    checkOutput("init_dout1", {31'b0, dout1}, 32'h1);
`endif

    // Reset with write disabled.
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 1'b1);
    // Write, then hold for three cycles while din changes. The one-shot
    // flag clears on its first edge with rst=0.
    applyStimulus(1'b0, 1'b1, 32'h8000_0004, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Reset and write in the same cycle: reset wins.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    // Writing the same value as the current output.
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b0);
    // Glitches between edges.
    applyGlitch(32'h1357_9BDF);
    applyGlitch(32'h0F0F_F0F0);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      if ((i % 37) == 5) begin
        applyGlitch($urandom);
      end else begin
        applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                      $urandom, $urandom_range(0, 7) == 0);
      end
    end

    // Drain the queue, then hold the inputs quiet.
    @(negedge clk);
    rst  = 1'b0;
    wen  = 1'b0;
    rst1 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
